rnm_step_extractor: RTL and testbench
=====================================

Name: rnm_step_extractor

Overview:
- Inverse of the team's real-valued accumulator flop. Consumes a stream of accumulated real samples `q` and recovers the per-cycle increment `incr = q[n] - q[n-1]`.
- Runs under a valid/ready handshake with a registered output stage.
- Tracks a saturating step count and latches a sticky error on NaN or Inf-class input.
- Sits downstream of accumulator models in RNM testbenches and formal harnesses, so accumulate→extract round-trips can be checked.

Parameters:
- CNT_W, 16, width of the saturating emitted-step counter.
- PREV_INIT, 0.0, value of the previous-sample register after reset. Matches the accumulator reset value, so the first step equals the first sample.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_q is presented.
- in_ready  output  1  block accepts in_q this cycle.
- in_q  input  real  accumulated sample.
- out_valid  output  1  out_incr holds an unconsumed step.
- out_ready  input  1  downstream consumes out_incr this cycle.
- out_incr  output  real  recovered increment.
- step_cnt  output  CNT_W  number of steps accepted by downstream, saturating.
- err  output  1  sticky NaN/Inf-class error.
- mono_err  output  1  sticky negative-step flag (see Optional Feature).

Behaviour:
- Clock and reset: clk, with reset rst synchronous and active-high.
- Reset values: out_valid=0, out_incr=0.0, prev=PREV_INIT, step_cnt=0, err=0, mono_err=0, state=RUN.
- Handshake:
  - in_ready = (state==RUN) ? (!out_valid || out_ready) : 1. The ERR state drains its input.
  - Input accept = in_valid && in_ready.
  - Output consume = out_valid && out_ready.
- Classification of in_q (combinational):
  - is_nan = !(in_q < 0.0) && !(in_q >= 0.0).
  - is_inf = (in_q + 1.0 == in_q). This deliberately also flags finite magnitudes ≥ 2^53, where a unit step is unrepresentable.
- FSM states: RUN, ERR.
  - RUN, accept with clean input:
    - out_incr <= in_q - prev; prev <= in_q; out_valid <= 1.
    - Latency is one cycle from accept to out_valid.
  - RUN, accept with is_nan || is_inf: err <= 1, state <= ERR, out_valid <= 0. prev and out_incr are unchanged, and the pending output is discarded.
  - RUN, consume without accept: out_valid <= 0.
  - Simultaneous consume and clean accept: out_valid stays 1 and out_incr takes the new value. Full throughput, no bubble.
  - ERR: all input is accepted and dropped; out_valid=0. Exit only via rst.
- Counter:
  - step_cnt increments on every consume.
  - It saturates at 2^CNT_W-1 with no wrap and holds at max.
- Stall: while out_valid && !out_ready, out_incr and prev hold and in_ready=0.
- Reset mid-transfer: rst dominates everything; the pending output is lost and the next step is computed against PREV_INIT.
- Step semantics: computed with real subtraction. No rounding or clamping is applied. A difference that overflows to Inf is not flagged; only the input is classified.

Optional Feature:
- Macro: RNM_STEP_MONO_CHECK_EN.
- Defined:
  - On a clean accept in RUN where in_q - prev < 0.0, mono_err <= 1 (sticky until rst).
  - The step is still emitted normally.
  - An embedded immediate assertion fires on every clean accept with a negative step: `assert(!(accept && clean && (in_q - prev) < 0.0))`.
- Undefined: mono_err is tied to 0 and no assertion is compiled.

Decomposition:
- Shared package rnm_pkg:
  - state enum {RUN, ERR}.
  - Functions is_nan(real) and is_inf_class(real), shared with the accumulator model and its formal properties.
  - Constant RNM_RESET_VAL = 0.0.
- Sub-module: none required. Optionally, rnm_classify (pure combinational NaN/Inf-class flags) if the functions cannot be used in the target tool flow.

Test Plan:
1. Reset, then send 1.5, 4.0, 3.0 with out_ready=1 → out_incr 1.5, 2.5, -1.0, each one cycle after accept; step_cnt=3. With RNM_STEP_MONO_CHECK_EN, mono_err=1 after the third sample.
2. Back-pressure: out_ready=0 after the first output of 2.0; offer 5.0 → in_ready=0 and out_incr holds 2.0. Then raise out_ready → 2.0 consumed and 3.0 emitted next, with nothing lost.
3. Send 1.0, then NaN (0.0/0.0), then 7.0 → one output of 1.0, err=1, state ERR; 7.0 accepted with in_ready=1 and no out_valid.
4. Send 1.0e300*1.0e300 (Inf), and separately 2^53 → err=1 in both runs; out_valid stays 0.
5. Continuous throughput with in_valid=out_ready=1 over 10 samples of k*0.25 → one output per cycle, each 0.25; step_cnt=10.
6. With CNT_W=2, consume 5 steps → step_cnt sticks at 3. Assert rst with out_valid=1 → next cycle out_valid=0, step_cnt=0, err=0; next sample 3.0 yields 3.0.

Source files
------------

// File: rtl/rnm_pkg.sv
// Shared RNM helpers: extractor state encoding, NaN / Inf-class input
// classification and the common accumulator reset value.
package rnm_pkg;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    localparam real RNM_RESET_VAL = 0.0;

    // A NaN fails every ordered comparison against zero.
    function automatic logic is_nan(input real x);
        return !(x < 0.0) && !(x >= 0.0);
    endfunction

    // True for +/-Inf and also for finite magnitudes >= 2^53, where a unit
    // step can no longer be represented.
    function automatic logic is_inf_class(input real x);
        return (x + 1.0 == x);
    endfunction

endpackage

// File: rtl/rnm_step_extractor.sv
// Recovers per-cycle increments from a stream of accumulated real samples.
// The valid/ready input feeds a registered output stage. The block keeps a
// saturating count of consumed steps and a sticky error flag for NaN and
// Inf-class input.
// Optional macro RNM_STEP_MONO_CHECK_EN: raises a sticky mono_err flag and
// fires an immediate assertion whenever a clean sample produces a negative
// step.
//
// state | meaning
// RUN   | normal extraction, one output register stage
// ERR   | bad input seen; drain and drop input until rst
module rnm_step_extractor
    import rnm_pkg::*;
#(
    parameter int  CNT_W     = 16,
    parameter real PREV_INIT = RNM_RESET_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  real              in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output real              out_incr,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err,
    output logic             mono_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    real              prev_q, prev_d;
    real              incr_q, incr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic accept;
    logic consume;
    logic bad;
    real  step;

    assign in_ready = (state_q == RUN) ? (!valid_q || out_ready) : 1'b1;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;
    assign bad      = is_nan(in_q) || is_inf_class(in_q);
    assign step     = in_q - prev_q;

`ifdef RNM_STEP_MONO_CHECK_EN
    logic mono_q, mono_d;

    // Sticky flag for negative steps on clean accepts in RUN.
    always_comb begin
        mono_d = mono_q;
        if (state_q == RUN && accept && !bad && step < 0.0) begin
            mono_d = 1'b1;
        end
    end

    // Flags each negative step the moment it is accepted.
    always @(posedge clk) begin
        if (!rst && state_q == RUN) begin
            assert (!(accept && !bad && step < 0.0));
        end
    end

    assign mono_err = mono_q;
`else
    assign mono_err = 1'b0;
`endif

    // Next-state logic for the FSM, the output stage and the step counter.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        incr_d  = incr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (consume && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (accept && bad) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                    valid_d = 1'b0;
                end else if (accept) begin
                    incr_d  = step;
                    prev_d  = in_q;
                    valid_d = 1'b1;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            ERR: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ERR;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register. Reset is synchronous and overrides any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            prev_q  <= PREV_INIT;
            incr_q  <= 0.0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef RNM_STEP_MONO_CHECK_EN
            mono_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            incr_q  <= incr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef RNM_STEP_MONO_CHECK_EN
            mono_q  <= mono_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_incr  = incr_q;
    assign step_cnt  = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rnm_step_extractor.sv
// Scoreboard bench for rnm_step_extractor. The stimulus process pushes
// expected increments into a queue, and a monitor pops one entry and compares
// it on every output consume. A second instance with CNT_W=2 covers counter
// saturation.
module tb_rnm_step_extractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    real        in_q = 0.0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    real        out_incr;
    logic [15:0] step_cnt;
    logic       err;
    logic       mono_err;

    logic       rst2 = 1'b1;
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    real        in_q2 = 0.0;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    real        out_incr2;
    logic [1:0] step_cnt2;
    logic       err2;
    logic       mono_err2;

    int  total = 0;
    int  bad_n = 0;
    int  cyc   = 0;
    real exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rnm_step_extractor #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_incr(out_incr), .step_cnt(step_cnt), .err(err), .mono_err(mono_err)
    );

    rnm_step_extractor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_q(in_q2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_incr(out_incr2), .step_cnt(step_cnt2), .err(err2), .mono_err(mono_err2)
    );

    // Monitor: every consumed output must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad_n++;
                $display("FAIL out_unexpected: got %f, expected no output", out_incr);
            end else begin
                real e;
                e = exp_q.pop_front();
                if (out_incr != e) begin
                    bad_n++;
                    $display("FAIL out_incr: got %f, expected %f", out_incr, e);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        total++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %f, expected %f", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one sample and hold it until accepted. in_valid stays high so
    // back-to-back calls stream one sample per cycle.
    task automatic send(input real v, input bit expect_out, input real e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_q = v;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad_n++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
        end
        if (expect_out) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        real z, nan_v, big, inf_v;
        int  c0;
        z     = 0.0;
        nan_v = z / z;
        big   = 1.0e300;
        inf_v = big * big;

        // Reset state and basic extraction with a negative step.
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_mono_err", mono_err, 0);
        chk_r("rst_out_incr", out_incr, 0.0);
        out_ready = 1'b1;
        send(1.5, 1, 1.5);
        chk("latency_out_valid", out_valid, 1);
        send(4.0, 1, 2.5);
        send(3.0, 1, -1.0);
        idle(2);
        chk("t1_step_cnt", step_cnt, 3);
`ifdef RNM_STEP_MONO_CHECK_EN
        chk("t1_mono_err", mono_err, 1);
`else
        chk("t1_mono_err", mono_err, 0);
`endif

        // Back-pressure: output holds and input is refused until drained.
        do_reset();
        out_ready = 1'b0;
        send(2.0, 1, 2.0);
        in_valid = 1'b1;
        in_q = 5.0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk_r("stall_out_incr", out_incr, 2.0);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        exp_q.push_back(3.0);
        @(posedge clk);
        #1;
        idle(2);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_step_cnt", step_cnt, 2);

        // NaN drives the block into ERR, which then drains its input.
        do_reset();
        out_ready = 1'b1;
        send(1.0, 1, 1.0);
        send(nan_v, 0, 0.0);
        chk("nan_err", err, 1);
        chk("nan_out_valid", out_valid, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("err_in_ready", in_ready, 1);
        send(7.0, 0, 0.0);
        idle(2);
        chk("err_drop_out_valid", out_valid, 0);
        chk("t3_step_cnt", step_cnt, 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Inf and 2^53 both count as Inf-class input.
        do_reset();
        send(inf_v, 0, 0.0);
        idle(1);
        chk("inf_err", err, 1);
        chk("inf_out_valid", out_valid, 0);
        do_reset();
        send(9007199254740992.0, 0, 0.0);
        idle(1);
        chk("big_err", err, 1);
        chk("big_out_valid", out_valid, 0);

        // Continuous throughput: one accepted sample per cycle.
        do_reset();
        out_ready = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 10; k++) send(k * 0.25, 1, 0.25);
        chk("thru_cycles", cyc - c0, 10);
        idle(2);
        chk("t5_step_cnt", step_cnt, 10);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Reset while an output is pending; the next step uses PREV_INIT.
        do_reset();
        out_ready = 1'b0;
        send(2.0, 1, 2.0);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_step_cnt", step_cnt, 0);
        chk("mid_rst_err", err, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        send(3.0, 1, 3.0);
        idle(2);
        chk("t6_step_cnt", step_cnt, 1);
        chk("t6_queue_empty", exp_q.size(), 0);

        // Saturation of the 2-bit counter after five consumed steps.
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        out_ready2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1;
            in_q2 = k * 1.0;
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sat_step_cnt", step_cnt2, 3);
        chk("sat_out_valid", out_valid2, 0);

        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end

endmodule
